// File: rtl/kplic_gateway_if.sv
// Interrupt gateway bus bundle: raw sources and register-side controls in,
// request pulses and in-service flags out.
interface kplic_gateway_if #(
    parameter int INT_NUM          = 32,
    parameter int INT_WIDTH        = 5,
    parameter int KPLIC_DATA_WIDTH = 32
);
    logic [INT_NUM-1:0]          ext_int;
    logic [KPLIC_DATA_WIDTH-1:0] int_enable;
    logic [KPLIC_DATA_WIDTH-1:0] int_type;
    logic                        int_complete;
    logic [INT_WIDTH-1:0]        int_complete_id;
    logic [INT_NUM-1:0]          valid_int_req;
    logic [INT_NUM-1:0]          int_in_service;

    modport master (
        output ext_int, int_enable, int_type, int_complete, int_complete_id,
        input  valid_int_req, int_in_service
    );

    modport slave (
        input  ext_int, int_enable, int_type, int_complete, int_complete_id,
        output valid_int_req, int_in_service
    );
endinterface

// File: rtl/kplic_gateway.sv
// KPLIC interrupt gateway: per-source synchronizer plus IDLE/WAIT request FSM.
// Optional KPLIC_EDGE_CNT_EN keeps a saturating count of edges seen while in WAIT.
module kplic_gateway #(
    parameter int INT_NUM          = 32,
    parameter int INT_WIDTH        = 5,
    parameter int KPLIC_DATA_WIDTH = 32
) (
    input logic       kplic_clk,
    input logic       kplic_rstn,
    kplic_gateway_if.slave gw
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    // Source 0 is reserved; every per-source vector is masked with this.
    localparam logic [INT_NUM-1:0] SRC_MASK = {{(INT_NUM-1){1'b1}}, 1'b0};

    logic [INT_NUM-1:0]          s1_r;
    logic [INT_NUM-1:0]          s2_r;
    logic [INT_NUM-1:0]          s2_d_r;
    logic [INT_NUM-1:0]          state_r;
    logic [INT_NUM-1:0]          state_nxt_s;
    logic [INT_NUM-1:0]          valid_r;
    logic [INT_NUM-1:0]          valid_nxt_s;
    logic [KPLIC_DATA_WIDTH-1:0] enable_s;
    logic [KPLIC_DATA_WIDTH-1:0] type_s;
    logic [INT_NUM-1:0]          edge_s;
    logic [INT_NUM-1:0]          trig_s;
    logic [INT_NUM-1:0]          hit_s;

`ifdef KPLIC_EDGE_CNT_EN
    logic [INT_NUM-1:0][1:0]     cnt_r;
    logic [INT_NUM-1:0][1:0]     cnt_nxt_s;

    // A completion only consumes a stored edge when one is stored, so no underflow.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic inc,
                                            input logic dec);
        logic [2:0] sum;
        sum = {1'b0, cnt} + {2'b00, inc} - {2'b00, (dec && (cnt != 2'd0))};
        if (sum > 3'd3) begin
            return 2'd3;
        end else begin
            return sum[1:0];
        end
    endfunction
`endif

    assign enable_s = gw.int_enable;
    assign type_s   = gw.int_type;

    // Two-flop synchronizer plus delayed copy for edge detection.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            s1_r   <= '0;
            s2_r   <= '0;
            s2_d_r <= '0;
        end else begin
            s1_r   <= gw.ext_int;
            s2_r   <= s1_r;
            s2_d_r <= s2_r;
        end
    end

    // Enable-qualified triggers: rising edge for edge sources, high level otherwise.
    always_comb begin
        edge_s = s2_r & ~s2_d_r & enable_s[INT_NUM-1:0] & type_s[INT_NUM-1:0] & SRC_MASK;
        trig_s = ((s2_r & enable_s[INT_NUM-1:0] & ~type_s[INT_NUM-1:0]) | edge_s) & SRC_MASK;
    end

    // Completion decode; IDs outside 1..INT_NUM-1 match no source.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < INT_NUM; i++) begin
            if (gw.int_complete && (gw.int_complete_id == INT_WIDTH'(i))) begin
                hit_s[i] = SRC_MASK[i];
            end else begin
                hit_s[i] = 1'b0;
            end
        end
    end

    // Per-source request FSM next-state and request pulse generation.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = '0;
`ifdef KPLIC_EDGE_CNT_EN
        cnt_nxt_s   = cnt_r;
`endif
        for (int i = 0; i < INT_NUM; i++) begin
            case (state_r[i])
                IDLE: begin
                    if (trig_s[i]) begin
                        valid_nxt_s[i] = 1'b1;
                        state_nxt_s[i] = WAIT;
                    end else begin
                        state_nxt_s[i] = IDLE;
                    end
                end
                WAIT: begin
`ifdef KPLIC_EDGE_CNT_EN
                    if (hit_s[i] && ((cnt_r[i] != 2'd0) || edge_s[i])) begin
                        valid_nxt_s[i] = 1'b1;
                        state_nxt_s[i] = WAIT;
                    end else if (hit_s[i]) begin
                        state_nxt_s[i] = IDLE;
                    end else begin
                        state_nxt_s[i] = WAIT;
                    end
                    cnt_nxt_s[i] = cnt_next(cnt_r[i], edge_s[i], hit_s[i]);
`else
                    if (hit_s[i]) begin
                        state_nxt_s[i] = IDLE;
                    end else begin
                        state_nxt_s[i] = WAIT;
                    end
`endif
                end
                default: begin
                    state_nxt_s[i] = IDLE;
                end
            endcase
        end
    end

    // FSM state and registered request pulses.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            state_r <= '0;
            valid_r <= '0;
        end else begin
            state_r <= state_nxt_s & SRC_MASK;
            valid_r <= valid_nxt_s & SRC_MASK;
        end
    end

`ifdef KPLIC_EDGE_CNT_EN
    // Saturating count of edges seen while waiting for completion.
    always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
        if (!kplic_rstn) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    assign gw.valid_int_req  = valid_r;
    assign gw.int_in_service = state_r;

endmodule

// File: tb/tb_kplic_gateway.sv
// Directed self-checking bench for kplic_gateway (default and KPLIC_EDGE_CNT_EN builds).
module tb_kplic_gateway;

    logic        kplic_clk = 1'b0;
    logic        kplic_rstn;
    int          total  = 0;
    int          passed = 0;
    int          p5     = 0;
    int          exp_p5;
    logic [31:0] seen   = 32'h0;

    kplic_gateway_if gw_if ();

    kplic_gateway dut (
        .kplic_clk  (kplic_clk),
        .kplic_rstn (kplic_rstn),
        .gw         (gw_if)
    );

    always #5 kplic_clk = ~kplic_clk;

    task automatic tick();
        @(posedge kplic_clk);
        #1;
        seen = seen | gw_if.valid_int_req;
        if (gw_if.valid_int_req[5]) p5 = p5 + 1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic complete(input logic [4:0] id);
        gw_if.int_complete    = 1'b1;
        gw_if.int_complete_id = id;
        tick();
        gw_if.int_complete    = 1'b0;
        gw_if.int_complete_id = 5'd0;
    endtask

    initial begin
        kplic_rstn            = 1'b0;
        gw_if.ext_int         = 32'h0;
        gw_if.int_enable      = 32'hFFFF_FF7F;
        gw_if.int_type        = 32'h0000_00A0;
        gw_if.int_complete    = 1'b0;
        gw_if.int_complete_id = 5'd0;
        ticks(3);
        check("rst_valid", gw_if.valid_int_req, 32'h0);
        check("rst_insvc", gw_if.int_in_service, 32'h0);
        #2 kplic_rstn = 1'b1;
        ticks(2);

        // Level source 3: pulse at N+2, silent in WAIT, re-pulse after completion
        gw_if.ext_int[3] = 1'b1;
        ticks(2);
        check("a_lat_early", gw_if.valid_int_req, 32'h0);
        tick();
        check("a_pulse", gw_if.valid_int_req, 32'h0000_0008);
        check("a_insvc", gw_if.int_in_service, 32'h0000_0008);
        seen = 32'h0;
        ticks(4);
        check("a_no_repulse", seen, 32'h0);
        complete(5'd3);
        check("a_cmpl_valid", gw_if.valid_int_req, 32'h0);
        check("a_cmpl_insvc", gw_if.int_in_service, 32'h0);
        tick();
        check("a_repulse", gw_if.valid_int_req, 32'h0000_0008);
        gw_if.ext_int[3] = 1'b0;
        ticks(3);
        complete(5'd3);
        tick();
        check("a_clean", gw_if.int_in_service, 32'h0);

        // Edge source 5: three edges in WAIT, then completions
        gw_if.ext_int[5] = 1'b1;
        ticks(3);
        check("b_pulse", gw_if.valid_int_req, 32'h0000_0020);
        p5 = 0;
        for (int k = 0; k < 3; k++) begin
            gw_if.ext_int[5] = 1'b0;
            ticks(2);
            gw_if.ext_int[5] = 1'b1;
            ticks(2);
        end
        ticks(3);
        check("b_wait_quiet", 32'(p5), 32'h0);
        for (int k = 0; k < 4; k++) begin
            complete(5'd5);
            ticks(2);
        end
`ifdef KPLIC_EDGE_CNT_EN
        exp_p5 = 3;
`else
        exp_p5 = 0;
`endif
        check("b_cmpl_pulses", 32'(p5), 32'(exp_p5));
        check("b_idle", gw_if.int_in_service, 32'h0);
        gw_if.ext_int[5] = 1'b0;
        ticks(3);

        // Edge source 7: edge while disabled is forgotten
        seen = 32'h0;
        gw_if.ext_int[7] = 1'b1;
        ticks(4);
        gw_if.int_enable[7] = 1'b1;
        ticks(4);
        check("c_no_pulse", seen, 32'h0);
        check("c_insvc", gw_if.int_in_service, 32'h0);
        gw_if.ext_int[7] = 1'b0;
        ticks(3);

        // Sources 1 and 31 together; bad/idle IDs ignored; completion is per source
        gw_if.ext_int[1]  = 1'b1;
        gw_if.ext_int[31] = 1'b1;
        ticks(3);
        check("d_pulse_both", gw_if.valid_int_req, 32'h8000_0002);
        gw_if.ext_int[1]  = 1'b0;
        gw_if.ext_int[31] = 1'b0;
        ticks(3);
        complete(5'd0);
        check("d_id0_insvc", gw_if.int_in_service, 32'h8000_0002);
        check("d_id0_valid", gw_if.valid_int_req, 32'h0);
        complete(5'd3);
        check("d_idle_cmpl", gw_if.int_in_service, 32'h8000_0002);
        complete(5'd31);
        check("d_id31", gw_if.int_in_service, 32'h0000_0002);
        complete(5'd1);
        check("d_id1", gw_if.int_in_service, 32'h0);

        // Reset while source 2 waits
        gw_if.ext_int[2] = 1'b1;
        ticks(3);
        check("e_pulse", gw_if.valid_int_req, 32'h0000_0004);
        gw_if.ext_int[2] = 1'b0;
        ticks(3);
        check("e_wait", gw_if.int_in_service, 32'h0000_0004);
        #2 kplic_rstn = 1'b0;
        #1;
        check("e_rst_insvc", gw_if.int_in_service, 32'h0);
        check("e_rst_valid", gw_if.valid_int_req, 32'h0);
        ticks(2);
        seen = 32'h0;
        #2 kplic_rstn = 1'b1;
        ticks(5);
        check("e_no_pulse", seen, 32'h0);
        check("e_post_insvc", gw_if.int_in_service, 32'h0);

        // Level source 4 high across reset release requests at R+2
        #2 kplic_rstn = 1'b0;
        gw_if.ext_int[4] = 1'b1;
        ticks(3);
        check("f_in_rst", gw_if.valid_int_req, 32'h0);
        #2 kplic_rstn = 1'b1;
        tick();
        check("f_r0", gw_if.valid_int_req, 32'h0);
        tick();
        check("f_r1", gw_if.valid_int_req, 32'h0);
        tick();
        check("f_r2", gw_if.valid_int_req, 32'h0000_0010);
        gw_if.ext_int[4] = 1'b0;
        ticks(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
